// File: rtl/trans_fifo_pkg.sv
// Shared types and width helpers for the multi-channel transactional FIFO.
package trans_fifo_pkg;
  localparam int CH_ADDR_WID_DEF = 6;

  function automatic int ch_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int depth(input int aw);
    return 1 << aw;
  endfunction

  // Pointer and pointer-set types at the default channel depth.
  typedef logic [CH_ADDR_WID_DEF:0] ptr_t;

  typedef struct packed {
    ptr_t wr_cmt;
    ptr_t wr_tr;
    ptr_t rd_cmt;
    ptr_t rd_tr;
  } ch_ptrs_t;
endpackage

// File: rtl/trans_fifo_mc_if.sv
// Write/read/flush bus of the multi-channel transactional FIFO.
interface trans_fifo_mc_if import trans_fifo_pkg::*; #(
  parameter int NUM_CH      = 4,
  parameter int CH_ADDR_WID = 6,
  parameter int DATA_WID    = 8
);
  localparam int CH_W = ch_w(NUM_CH);

  logic [CH_W-1:0]        wr_ch_i;
  logic                   data_valid_i;
  logic [DATA_WID-1:0]    data_i;
  logic                   full_o;
  logic [CH_ADDR_WID:0]   free_o;
  logic                   fill_trans_done_i;
  logic                   fill_trans_success_i;
  logic [CH_W-1:0]        rd_ch_i;
  logic                   pop_data_i;
  logic                   data_available_o;
  logic                   is_last_o;
  logic [DATA_WID-1:0]    data_o;
  logic [CH_ADDR_WID:0]   avail_cnt_o;
  logic                   pop_trans_done_i;
  logic                   pop_trans_success_i;
  logic                   flush_i;
  logic [CH_W-1:0]        flush_ch_i;
  logic [NUM_CH-1:0]      ch_full_vec_o;
  logic [NUM_CH-1:0]      ch_avail_vec_o;

  modport slave (
    input  wr_ch_i, data_valid_i, data_i, fill_trans_done_i, fill_trans_success_i,
           rd_ch_i, pop_data_i, pop_trans_done_i, pop_trans_success_i, flush_i, flush_ch_i,
    output full_o, free_o, data_available_o, is_last_o, data_o, avail_cnt_o,
           ch_full_vec_o, ch_avail_vec_o
  );

  modport master (
    output wr_ch_i, data_valid_i, data_i, fill_trans_done_i, fill_trans_success_i,
           rd_ch_i, pop_data_i, pop_trans_done_i, pop_trans_success_i, flush_i, flush_ch_i,
    input  full_o, free_o, data_available_o, is_last_o, data_o, avail_cnt_o,
           ch_full_vec_o, ch_avail_vec_o
  );
endinterface

// File: rtl/trans_fifo_ch_ptrs.sv
// One channel's committed/transaction pointer pair for each side, plus derived status.
module trans_fifo_ch_ptrs #(
  parameter int AW = 6
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_flush,
  input  logic          i_wr_inc,
  input  logic          i_fill_done,
  input  logic          i_fill_ok,
  input  logic          i_rd_inc,
  input  logic          i_pop_done,
  input  logic          i_pop_ok,
  output logic          o_full,
  output logic          o_avail,
  output logic          o_is_last,
  output logic          o_cmt_pend,
  output logic [AW:0]   o_free,
  output logic [AW:0]   o_avail_cnt,
  output logic [AW-1:0] o_wr_idx,
  output logic [AW-1:0] o_rd_idx
);
  typedef struct packed {
    logic [AW:0] wr_cmt;
    logic [AW:0] wr_tr;
    logic [AW:0] rd_cmt;
    logic [AW:0] rd_tr;
  } ptrs_t;

  localparam logic [AW:0] ONE   = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  ptrs_t r_p;
  logic [AW:0] w_rd_nxt;

  // Done beats the handshake on each side; the top already masks the increment.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_p <= '0;
    end else begin
      if (i_fill_done) begin
        if (i_fill_ok) r_p.wr_cmt <= r_p.wr_tr;
        else           r_p.wr_tr  <= r_p.wr_cmt;
      end else if (i_wr_inc) begin
        r_p.wr_tr <= r_p.wr_tr + ONE;
      end
      if (i_pop_done) begin
        if (i_pop_ok) r_p.rd_cmt <= r_p.rd_tr;
        else          r_p.rd_tr  <= r_p.rd_cmt;
      end else if (i_rd_inc) begin
        r_p.rd_tr <= w_rd_nxt;
      end
    end
  end

  assign w_rd_nxt    = r_p.rd_tr + ONE;
  assign o_full      = (r_p.wr_tr[AW] != r_p.rd_cmt[AW]) &&
                       (r_p.wr_tr[AW-1:0] == r_p.rd_cmt[AW-1:0]);
  assign o_free      = DEPTH - (r_p.wr_tr - r_p.rd_cmt);
  assign o_avail     = (r_p.rd_tr != r_p.wr_cmt);
  assign o_avail_cnt = r_p.wr_cmt - r_p.rd_tr;
  assign o_is_last   = o_avail && (w_rd_nxt == r_p.wr_cmt);
  assign o_cmt_pend  = (r_p.wr_cmt != r_p.rd_cmt);
  assign o_wr_idx    = r_p.wr_tr[AW-1:0];
  assign o_rd_idx    = r_p.rd_tr[AW-1:0];
endmodule

// File: rtl/trans_fifo_mc.sv
// Multi-channel transactional FIFO: shared storage, per-channel pointer sets, channel muxes.
module trans_fifo_mc import trans_fifo_pkg::*; #(
  parameter int NUM_CH      = 4,
  parameter int CH_ADDR_WID = 6,
  parameter int DATA_WID    = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  trans_fifo_mc_if.slave   bus
);
  localparam int CH_W = ch_w(NUM_CH);
  localparam int D    = depth(CH_ADDR_WID);

  logic [DATA_WID-1:0] r_mem [(2**CH_W)*D];

  logic [NUM_CH-1:0]                  w_full, w_avail, w_last, w_pend;
  logic [NUM_CH-1:0]                  w_flush, w_wr_inc, w_fill_done, w_rd_inc, w_pop_done;
  logic [NUM_CH-1:0][CH_ADDR_WID:0]   w_free, w_cnt;
  logic [NUM_CH-1:0][CH_ADDR_WID-1:0] w_wr_idx, w_rd_idx;
  logic                               w_wr_hs, w_rd_hs, w_mem_we;

  assign w_wr_hs = bus.data_valid_i && !w_full[bus.wr_ch_i] && !bus.fill_trans_done_i;
  assign w_rd_hs = bus.pop_data_i && w_avail[bus.rd_ch_i] && !bus.pop_trans_done_i;

  genvar c;
  generate
    for (c = 0; c < NUM_CH; c++) begin : g_ch
      assign w_flush[c]     = bus.flush_i && (bus.flush_ch_i == CH_W'(c));
      assign w_wr_inc[c]    = w_wr_hs && (bus.wr_ch_i == CH_W'(c));
      assign w_fill_done[c] = bus.fill_trans_done_i && (bus.wr_ch_i == CH_W'(c));
      assign w_rd_inc[c]    = w_rd_hs && (bus.rd_ch_i == CH_W'(c));
      assign w_pop_done[c]  = bus.pop_trans_done_i && (bus.rd_ch_i == CH_W'(c));

      trans_fifo_ch_ptrs #(.AW(CH_ADDR_WID)) u_ptrs (
        .i_clk       (clk_i),
        .i_rst       (rst_i),
        .i_flush     (w_flush[c]),
        .i_wr_inc    (w_wr_inc[c]),
        .i_fill_done (w_fill_done[c]),
        .i_fill_ok   (bus.fill_trans_success_i),
        .i_rd_inc    (w_rd_inc[c]),
        .i_pop_done  (w_pop_done[c]),
        .i_pop_ok    (bus.pop_trans_success_i),
        .o_full      (w_full[c]),
        .o_avail     (w_avail[c]),
        .o_is_last   (w_last[c]),
        .o_cmt_pend  (w_pend[c]),
        .o_free      (w_free[c]),
        .o_avail_cnt (w_cnt[c]),
        .o_wr_idx    (w_wr_idx[c]),
        .o_rd_idx    (w_rd_idx[c])
      );
    end
  endgenerate

  // A flushed or resetting channel must not take the write either.
  assign w_mem_we = w_wr_hs && !rst_i && !(bus.flush_i && (bus.flush_ch_i == bus.wr_ch_i));

  always_ff @(posedge clk_i) begin
    if (w_mem_we) r_mem[{bus.wr_ch_i, w_wr_idx[bus.wr_ch_i]}] <= bus.data_i;
  end

  assign bus.full_o           = w_full[bus.wr_ch_i];
  assign bus.free_o           = w_free[bus.wr_ch_i];
  assign bus.data_available_o = w_avail[bus.rd_ch_i];
  assign bus.is_last_o        = w_last[bus.rd_ch_i];
  assign bus.avail_cnt_o      = w_cnt[bus.rd_ch_i];
  assign bus.data_o           = r_mem[{bus.rd_ch_i, w_rd_idx[bus.rd_ch_i]}];
  assign bus.ch_full_vec_o    = w_full;
  assign bus.ch_avail_vec_o   = w_pend;
endmodule

// File: tb/tb_trans_fifo_mc.sv
// Directed bench for trans_fifo_mc: commit/rollback on both sides, full/wrap, done priority, flush, reset.
module tb_trans_fifo_mc;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk_i = ~clk_i;

  trans_fifo_mc_if #(.NUM_CH(4), .CH_ADDR_WID(6), .DATA_WID(8)) bus ();

  trans_fifo_mc #(.NUM_CH(4), .CH_ADDR_WID(6), .DATA_WID(8)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  task automatic idle();
    bus.wr_ch_i = '0; bus.data_valid_i = 1'b0; bus.data_i = '0;
    bus.fill_trans_done_i = 1'b0; bus.fill_trans_success_i = 1'b0;
    bus.rd_ch_i = '0; bus.pop_data_i = 1'b0;
    bus.pop_trans_done_i = 1'b0; bus.pop_trans_success_i = 1'b0;
    bus.flush_i = 1'b0; bus.flush_ch_i = '0;
  endtask

  task automatic cyc();
    @(posedge clk_i); #1;
  endtask

  task automatic wr(input logic [1:0] ch, input logic [7:0] d);
    idle(); bus.wr_ch_i = ch; bus.data_valid_i = 1'b1; bus.data_i = d; cyc(); idle();
  endtask

  task automatic fill_done(input logic [1:0] ch, input logic ok);
    idle(); bus.wr_ch_i = ch; bus.fill_trans_done_i = 1'b1; bus.fill_trans_success_i = ok; cyc(); idle();
  endtask

  task automatic pop(input logic [1:0] ch);
    idle(); bus.rd_ch_i = ch; bus.pop_data_i = 1'b1; cyc(); idle();
  endtask

  task automatic pop_done(input logic [1:0] ch, input logic ok);
    idle(); bus.rd_ch_i = ch; bus.pop_trans_done_i = 1'b1; bus.pop_trans_success_i = ok; cyc(); idle();
  endtask

  task automatic test_reset();
    idle(); rst_i = 1'b1; cyc(); cyc(); rst_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      bus.wr_ch_i = 2'(c); bus.rd_ch_i = 2'(c); #1;
      n_chk++; if (bus.full_o !== 1'b0) begin n_fail++; $display("FAIL rst_full ch%0d got %b exp 0", c, bus.full_o); end
      n_chk++; if (bus.free_o !== 7'd64) begin n_fail++; $display("FAIL rst_free ch%0d got %0d exp 64", c, bus.free_o); end
      n_chk++; if (bus.data_available_o !== 1'b0) begin n_fail++; $display("FAIL rst_avail ch%0d got %b exp 0", c, bus.data_available_o); end
      n_chk++; if (bus.avail_cnt_o !== 7'd0) begin n_fail++; $display("FAIL rst_cnt ch%0d got %0d exp 0", c, bus.avail_cnt_o); end
      n_chk++; if (bus.is_last_o !== 1'b0) begin n_fail++; $display("FAIL rst_last ch%0d got %b exp 0", c, bus.is_last_o); end
    end
    n_chk++; if (bus.ch_full_vec_o !== 4'b0000) begin n_fail++; $display("FAIL rst_fullvec got %b exp 0000", bus.ch_full_vec_o); end
    n_chk++; if (bus.ch_avail_vec_o !== 4'b0000) begin n_fail++; $display("FAIL rst_availvec got %b exp 0000", bus.ch_avail_vec_o); end
    idle();
  endtask

  task automatic test_commit();
    wr(2'd1, 8'h11); wr(2'd1, 8'h22); wr(2'd1, 8'h33);
    bus.rd_ch_i = 2'd1; #1;
    n_chk++; if (bus.data_available_o !== 1'b0) begin n_fail++; $display("FAIL precommit_avail got %b exp 0", bus.data_available_o); end
    fill_done(2'd1, 1'b1);
    n_chk++; if (bus.ch_avail_vec_o !== 4'b0010) begin n_fail++; $display("FAIL cmt_availvec got %b exp 0010", bus.ch_avail_vec_o); end
    bus.rd_ch_i = 2'd1; #1;
    n_chk++; if (bus.data_o !== 8'h11) begin n_fail++; $display("FAIL cmt_data0 got %h exp 11", bus.data_o); end
    n_chk++; if (bus.avail_cnt_o !== 7'd3) begin n_fail++; $display("FAIL cmt_cnt got %0d exp 3", bus.avail_cnt_o); end
    n_chk++; if (bus.is_last_o !== 1'b0) begin n_fail++; $display("FAIL cmt_last0 got %b exp 0", bus.is_last_o); end
    pop(2'd1); pop(2'd1);
    bus.rd_ch_i = 2'd1; #1;
    n_chk++; if (bus.data_o !== 8'h33) begin n_fail++; $display("FAIL cmt_data2 got %h exp 33", bus.data_o); end
    n_chk++; if (bus.is_last_o !== 1'b1) begin n_fail++; $display("FAIL cmt_last2 got %b exp 1", bus.is_last_o); end
    n_chk++; if (bus.avail_cnt_o !== 7'd1) begin n_fail++; $display("FAIL cmt_cnt2 got %0d exp 1", bus.avail_cnt_o); end
    pop(2'd1);
    pop_done(2'd1, 1'b1);
    n_chk++; if (bus.ch_avail_vec_o !== 4'b0000) begin n_fail++; $display("FAIL rdcmt_availvec got %b exp 0000", bus.ch_avail_vec_o); end
  endtask

  task automatic test_fill_rollback();
    for (int i = 0; i < 5; i++) wr(2'd0, 8'h50 + 8'(i));
    bus.wr_ch_i = 2'd0; #1;
    n_chk++; if (bus.free_o !== 7'd59) begin n_fail++; $display("FAIL fr_free_open got %0d exp 59", bus.free_o); end
    fill_done(2'd0, 1'b0);
    bus.wr_ch_i = 2'd0; bus.rd_ch_i = 2'd0; #1;
    n_chk++; if (bus.free_o !== 7'd64) begin n_fail++; $display("FAIL fr_free got %0d exp 64", bus.free_o); end
    n_chk++; if (bus.data_available_o !== 1'b0) begin n_fail++; $display("FAIL fr_avail got %b exp 0", bus.data_available_o); end
    wr(2'd0, 8'hA0); fill_done(2'd0, 1'b1);
    bus.rd_ch_i = 2'd0; #1;
    n_chk++; if (bus.data_o !== 8'hA0) begin n_fail++; $display("FAIL fr_addr0 got %h exp a0", bus.data_o); end
    n_chk++; if (bus.avail_cnt_o !== 7'd1) begin n_fail++; $display("FAIL fr_cnt got %0d exp 1", bus.avail_cnt_o); end
    pop(2'd0); pop_done(2'd0, 1'b1);
  endtask

  task automatic test_pop_rollback();
    wr(2'd2, 8'hC1); wr(2'd2, 8'hC2); wr(2'd2, 8'hC3); fill_done(2'd2, 1'b1);
    pop(2'd2); pop(2'd2);
    bus.rd_ch_i = 2'd2; #1;
    n_chk++; if (bus.data_o !== 8'hC3) begin n_fail++; $display("FAIL pr_data_mid got %h exp c3", bus.data_o); end
    pop_done(2'd2, 1'b0);
    bus.rd_ch_i = 2'd2; bus.wr_ch_i = 2'd2; #1;
    n_chk++; if (bus.data_o !== 8'hC1) begin n_fail++; $display("FAIL pr_data got %h exp c1", bus.data_o); end
    n_chk++; if (bus.avail_cnt_o !== 7'd3) begin n_fail++; $display("FAIL pr_cnt got %0d exp 3", bus.avail_cnt_o); end
    n_chk++; if (bus.free_o !== 7'd61) begin n_fail++; $display("FAIL pr_free got %0d exp 61", bus.free_o); end
    idle();
  endtask

  task automatic test_full_wrap();
    for (int i = 0; i < 63; i++) wr(2'd3, 8'(i));
    bus.wr_ch_i = 2'd3; #1;
    n_chk++; if (bus.free_o !== 7'd1 || bus.full_o !== 1'b0) begin n_fail++; $display("FAIL fw_63 got free %0d full %b exp 1 0", bus.free_o, bus.full_o); end
    wr(2'd3, 8'd63);
    bus.wr_ch_i = 2'd3; #1;
    n_chk++; if (bus.full_o !== 1'b1) begin n_fail++; $display("FAIL fw_full got %b exp 1", bus.full_o); end
    n_chk++; if (bus.free_o !== 7'd0) begin n_fail++; $display("FAIL fw_free0 got %0d exp 0", bus.free_o); end
    n_chk++; if (bus.ch_full_vec_o !== 4'b1000) begin n_fail++; $display("FAIL fw_fullvec got %b exp 1000", bus.ch_full_vec_o); end
    wr(2'd3, 8'hFF);
    fill_done(2'd3, 1'b1);
    bus.rd_ch_i = 2'd3; bus.wr_ch_i = 2'd3; #1;
    n_chk++; if (bus.avail_cnt_o !== 7'd64) begin n_fail++; $display("FAIL fw_cnt got %0d exp 64", bus.avail_cnt_o); end
    n_chk++; if (bus.data_o !== 8'h00) begin n_fail++; $display("FAIL fw_drop got %h exp 00", bus.data_o); end
    pop(2'd3);
    bus.rd_ch_i = 2'd3; bus.wr_ch_i = 2'd3; bus.pop_trans_done_i = 1'b1; bus.pop_trans_success_i = 1'b1; #1;
    n_chk++; if (bus.full_o !== 1'b1) begin n_fail++; $display("FAIL fw_full_during_cmt got %b exp 1", bus.full_o); end
    cyc(); idle(); bus.wr_ch_i = 2'd3; #1;
    n_chk++; if (bus.full_o !== 1'b0 || bus.free_o !== 7'd1) begin n_fail++; $display("FAIL fw_freed got full %b free %0d exp 0 1", bus.full_o, bus.free_o); end
    wr(2'd3, 8'hEE); fill_done(2'd3, 1'b1);
    bus.wr_ch_i = 2'd3; #1;
    n_chk++; if (bus.full_o !== 1'b1) begin n_fail++; $display("FAIL fw_refull got %b exp 1", bus.full_o); end
    for (int i = 0; i < 63; i++) pop(2'd3);
    bus.rd_ch_i = 2'd3; #1;
    n_chk++; if (bus.data_o !== 8'hEE || bus.is_last_o !== 1'b1) begin n_fail++; $display("FAIL fw_wrap got %h last %b exp ee 1", bus.data_o, bus.is_last_o); end
    idle();
  endtask

  task automatic test_done_wins();
    wr(2'd0, 8'h77);
    idle(); bus.wr_ch_i = 2'd0; bus.data_valid_i = 1'b1; bus.data_i = 8'h99;
    bus.fill_trans_done_i = 1'b1; bus.fill_trans_success_i = 1'b1; cyc(); idle();
    bus.wr_ch_i = 2'd0; bus.rd_ch_i = 2'd0; #1;
    n_chk++; if (bus.free_o !== 7'd63) begin n_fail++; $display("FAIL dw_free got %0d exp 63", bus.free_o); end
    n_chk++; if (bus.avail_cnt_o !== 7'd1) begin n_fail++; $display("FAIL dw_cnt got %0d exp 1", bus.avail_cnt_o); end
    n_chk++; if (bus.data_o !== 8'h77) begin n_fail++; $display("FAIL dw_data got %h exp 77", bus.data_o); end
    pop(2'd0);
    bus.rd_ch_i = 2'd0; #1;
    n_chk++; if (bus.data_o !== 8'h52) begin n_fail++; $display("FAIL dw_nowrite got %h exp 52", bus.data_o); end
    n_chk++; if (bus.data_available_o !== 1'b0) begin n_fail++; $display("FAIL dw_avail got %b exp 0", bus.data_available_o); end
    pop_done(2'd0, 1'b1);
  endtask

  task automatic test_flush_reset();
    wr(2'd0, 8'h01); wr(2'd1, 8'h10); wr(2'd0, 8'h02); wr(2'd1, 8'h20);
    fill_done(2'd0, 1'b1);
    wr(2'd0, 8'h03);
    idle(); bus.flush_i = 1'b1; bus.flush_ch_i = 2'd0;
    bus.wr_ch_i = 2'd1; bus.data_valid_i = 1'b1; bus.data_i = 8'h30; cyc(); idle();
    bus.wr_ch_i = 2'd0; bus.rd_ch_i = 2'd0; #1;
    n_chk++; if (bus.free_o !== 7'd64) begin n_fail++; $display("FAIL fl_free got %0d exp 64", bus.free_o); end
    n_chk++; if (bus.data_available_o !== 1'b0) begin n_fail++; $display("FAIL fl_avail got %b exp 0", bus.data_available_o); end
    n_chk++; if (bus.ch_avail_vec_o[0] !== 1'b0) begin n_fail++; $display("FAIL fl_vec0 got %b exp 0", bus.ch_avail_vec_o[0]); end
    idle(); bus.flush_i = 1'b1; bus.flush_ch_i = 2'd0;
    bus.wr_ch_i = 2'd0; bus.data_valid_i = 1'b1; bus.data_i = 8'h04; cyc(); idle();
    bus.wr_ch_i = 2'd0; #1;
    n_chk++; if (bus.free_o !== 7'd64) begin n_fail++; $display("FAIL fl_wr_override got %0d exp 64", bus.free_o); end
    fill_done(2'd1, 1'b1);
    bus.rd_ch_i = 2'd1; #1;
    n_chk++; if (bus.avail_cnt_o !== 7'd3) begin n_fail++; $display("FAIL fl_ch1_cnt got %0d exp 3", bus.avail_cnt_o); end
    n_chk++; if (bus.data_o !== 8'h10) begin n_fail++; $display("FAIL fl_ch1_data got %h exp 10", bus.data_o); end
    wr(2'd1, 8'h40);
    rst_i = 1'b1; bus.wr_ch_i = 2'd1; bus.data_valid_i = 1'b1; bus.data_i = 8'h41; cyc(); rst_i = 1'b0; idle();
    for (int c = 0; c < 4; c++) begin
      bus.wr_ch_i = 2'(c); bus.rd_ch_i = 2'(c); #1;
      n_chk++; if (bus.free_o !== 7'd64 || bus.full_o !== 1'b0) begin n_fail++; $display("FAIL rs_wr ch%0d got free %0d full %b exp 64 0", c, bus.free_o, bus.full_o); end
      n_chk++; if (bus.data_available_o !== 1'b0 || bus.avail_cnt_o !== 7'd0 || bus.is_last_o !== 1'b0) begin
        n_fail++; $display("FAIL rs_rd ch%0d got avail %b cnt %0d last %b exp 0 0 0", c, bus.data_available_o, bus.avail_cnt_o, bus.is_last_o); end
    end
    n_chk++; if (bus.ch_full_vec_o !== 4'b0000 || bus.ch_avail_vec_o !== 4'b0000) begin
      n_fail++; $display("FAIL rs_vecs got %b %b exp 0000 0000", bus.ch_full_vec_o, bus.ch_avail_vec_o); end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_commit();
    test_fill_rollback();
    test_pop_rollback();
    test_full_wrap();
    test_done_wins();
    test_flush_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/trans_fifo_mc.md
Name: trans_fifo_mc

Overview:
- Multi-channel transactional FIFO with internal storage, for per-endpoint USB buffering.
- NUM_CH independent channels share one write port and one read port. Each channel owns a fixed region of 2**CH_ADDR_WID entries.
- Writes and reads are grouped into transactions. Each transaction is committed on success or rolled back on failure, per channel. Channels may interleave their open transactions freely.
- Adds synchronous reset, per-channel flush, level reporting and per-channel status vectors.

Parameters:
- NUM_CH, 4, number of channels (>=1); CH_W = max(1, $clog2(NUM_CH)).
- CH_ADDR_WID, 6, log2 of entries per channel (depth D = 2**CH_ADDR_WID).
- DATA_WID, 8, entry width in bits.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- wr_ch_i  in  CH_W  channel addressed by write-side inputs and outputs
- data_valid_i  in  1  write request
- data_i  in  DATA_WID  write data
- full_o  out  1  wr_ch_i channel cannot accept data
- free_o  out  CH_ADDR_WID+1  free entries of wr_ch_i channel
- fill_trans_done_i  in  1  end write transaction on wr_ch_i
- fill_trans_success_i  in  1  commit (1) or roll back (0) on done
- rd_ch_i  in  CH_W  channel addressed by read-side inputs and outputs
- pop_data_i  in  1  read request
- data_available_o  out  1  rd_ch_i has committed, not-yet-popped data in the current read transaction
- is_last_o  out  1  current data_o is the last committed entry
- data_o  out  DATA_WID  entry at the rd_ch_i transaction read pointer (combinational)
- avail_cnt_o  out  CH_ADDR_WID+1  committed entries remaining for the rd_ch_i transaction
- pop_trans_done_i  in  1  end read transaction on rd_ch_i
- pop_trans_success_i  in  1  commit (1) or roll back (0) on done
- flush_i  in  1  clear one channel
- flush_ch_i  in  CH_W  channel to clear
- ch_full_vec_o  out  NUM_CH  per-channel full
- ch_avail_vec_o  out  NUM_CH  per-channel committed data not yet read-committed (wr_cmt != rd_cmt)

Behaviour:
- Pointers per channel, each CH_ADDR_WID+1 bits including a wrap bit:
  - wr_cmt: committed write pointer
  - wr_tr: transaction write pointer
  - rd_cmt: committed read pointer
  - rd_tr: transaction read pointer
- Increments use natural overflow; no bounds logic is needed because depth is a power of two.
- Memory address = {channel, ptr[CH_ADDR_WID-1:0]}. Storage is an internal array with asynchronous read and no reset.
- Reset:
  - All pointers of all channels become 0 on the next edge.
  - After reset: full_o=0, free_o=D, data_available_o=0, avail_cnt_o=0, is_last_o=0, both vectors 0.
  - Reset overrides every other input.
- full for channel c: wr_tr.wrap != rd_cmt.wrap and the low bits are equal.
- free_o = D - (wr_tr - rd_cmt), computed modulo 2**(CH_ADDR_WID+1).
- data_available = (rd_tr != wr_cmt).
- avail_cnt_o = wr_cmt - rd_tr, modulo 2**(CH_ADDR_WID+1).
- is_last_o = data_available_o and (rd_tr+1 == wr_cmt).
- Write handshake = data_valid_i and !full_o and !fill_trans_done_i.
  - On handshake: mem[wr_ch_i, wr_tr] <= data_i and wr_tr++ at the edge.
  - data_valid_i while full is dropped silently; no state change.
- Read handshake = pop_data_i and data_available_o and !pop_trans_done_i. On handshake, rd_tr++ at the edge.
- Done and handshake asserted in the same cycle: done wins and the handshake is ignored, including the memory write.
- fill_trans_done_i:
  - success: wr_cmt <= wr_tr.
  - failure: wr_tr <= wr_cmt.
- pop_trans_done_i:
  - success: rd_cmt <= rd_tr.
  - failure: rd_tr <= rd_cmt.
- Latency:
  - Committed write data becomes visible to data_available_o the cycle after commit.
  - Space freed by a read commit is visible to full_o/free_o the cycle after the commit.
- Write and read sides act on the same channel in the same cycle independently; each updates only its own pointers.
- Flush:
  - flush_i sets all four pointers of flush_ch_i to 0 and overrides every write/read/done action targeting that channel in that cycle.
  - Other channels proceed normally.
- A transaction left open on a channel persists while other channels are addressed.

Decomposition:
- Package trans_fifo_pkg:
  - CH_W and D derivation functions
  - ptr_t typedef (CH_ADDR_WID+1 bits)
  - ch_ptrs_t struct {wr_cmt, wr_tr, rd_cmt, rd_tr}
- Sub-module trans_fifo_ch_ptrs:
  - One channel's pointer set: increments, commit/rollback, flush, reset priority.
  - Outputs full, available, free, avail_cnt.
  - Instantiated NUM_CH times with a generate loop.
- Top level holds the shared memory array and the channel muxes.

Test Plan:
- Reset, then write 0x11,0x22,0x33 to ch1 and commit -> ch_avail_vec_o=4'b0010; on rd_ch_i=1: data_o=0x11, avail_cnt_o=3; after 2 pops is_last_o=1 with data_o=0x33.
- Write 5 entries to ch0, fill done with success=0 -> free_o=64, data_available_o=0; next write lands at address 0 of ch0.
- Pop 2 of 3 committed entries on ch2, pop done with success=0 -> data_o returns to the first entry, avail_cnt_o=3, free_o unchanged.
- Fill ch3 with 64 entries -> full_o=1, 65th valid dropped; commit; read-commit 1 entry -> the next cycle full_o=0, free_o=1; further writes wrap to address 0.
- data_valid_i and fill_trans_done_i (success) in the same cycle on ch0 -> no memory write and no pointer increment; wr_cmt equals the pre-cycle wr_tr.
- Interleave open transactions on ch0 and ch1, flush ch0 mid-transaction, assert rst_i during an open ch1 transaction -> ch0 is empty the next cycle and ch1 is unaffected by the flush; after reset all outputs are at their reset values.
